toggle_cover_collector: RTL and testbench

TOGGLE_COVER_COLLECTOR -- requirements
Module: toggle_cover_collector

---
 rtl/toggle_cover_collector.sv | 107 ++++++++++
 tb/tb_toggle_cover_collector.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/toggle_cover_collector.sv
// Toggle-coverage collector: records first hits on WIDTH toggle points and reports
// each newly covered point once, lowest index first, over a valid/ready stream.
module toggle_cover_collector #(
  parameter int          WIDTH       = 40,
  parameter int unsigned COVER_INDEX = 0,
  parameter int          IDX_W       = 64,
  parameter int          CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] valid,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic [CNT_W-1:0] hit_count,
  output logic             all_covered,
  output logic             pending_any,
  output logic             dbg_state
);
  // Handshake: a report transfers on a rising edge where out_valid and out_ready are
  // both high; while out_valid is high and out_ready low, out_index is held stable.

  localparam int KW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PC_W  = $clog2(WIDTH + 1);
  localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t           state;
  logic [WIDTH-1:0] covered;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] new_hits;
  logic [WIDTH-1:0] low_hot;
  logic [WIDTH-1:0] pending_next;
  logic [KW-1:0]    low_k;
  logic [PC_W-1:0]  pc;
  logic [SUM_W-1:0] sum;
  logic [CNT_W-1:0] cnt_next;
  logic [IDX_W-1:0] next_index;
  logic             load;

  always_comb begin
    new_hits = enable ? (valid & ~covered) : '0;
    low_k = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pending[i]) low_k = KW'(i);
    end
    low_hot = {{(WIDTH-1){1'b0}}, 1'b1} << low_k;
    pc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pc = pc + PC_W'(new_hits[i]);
    end
    sum = SUM_W'(hit_count) + SUM_W'(pc);
    cnt_next = (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
    // A load is possible whenever the output slot is empty or being accepted.
    load = (|pending) && ((state == IDLE) || out_ready);
    // The loaded bit is already covered, so it can never collide with a new hit.
    pending_next = (pending & ~({WIDTH{load}} & low_hot)) | new_hits;
    next_index = IDX_W'(COVER_INDEX) + IDX_W'(low_k);
  end

  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      state     <= IDLE;
      covered   <= '0;
      pending   <= '0;
      hit_count <= '0;
      out_valid <= 1'b0;
      out_index <= '0;
    end else begin
      covered   <= covered | new_hits;
      pending   <= pending_next;
      hit_count <= cnt_next;
      case (state)
        IDLE: begin
          if (load) begin
            out_index <= next_index;
            out_valid <= 1'b1;
            state     <= PRESENT;
          end
        end
        PRESENT: begin
          if (out_ready) begin
            if (load) begin
              out_index <= next_index;
            end else begin
              out_valid <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign all_covered = &covered;
  assign pending_any = (|pending) | out_valid;
  assign dbg_state   = (state == PRESENT);

endmodule

// File: tb/tb_toggle_cover_collector.sv
// Directed bench for toggle_cover_collector: vector table for single-cycle behaviour,
// hand-written sequences for clear/reset mid-drain and full-coverage saturation.
module tb_toggle_cover_collector;
  localparam int WIDTH = 40;
  localparam int IDX_W = 64;
  localparam int CNT_W = 4;

  logic             clock;
  logic             reset;
  logic             enable;
  logic [WIDTH-1:0] valid;
  logic             clear;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_index;
  logic [CNT_W-1:0] hit_count;
  logic             all_covered;
  logic             pending_any;
  logic             dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  logic [IDX_W-1:0] exp_q[$];

  typedef struct {
    logic             clr;
    logic             en;
    logic [WIDTH-1:0] v;
    logic             rdy;
    logic             ov;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] hc;
    logic             pa;
  } vec_t;

  vec_t vecs[$];

  toggle_cover_collector #(
    .WIDTH(WIDTH), .COVER_INDEX(100), .IDX_W(IDX_W), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .valid(valid), .clear(clear),
    .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
    .hit_count(hit_count), .all_covered(all_covered), .pending_any(pending_any),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [IDX_W-1:0] act,
                       input logic [IDX_W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic clr, input logic en, input logic [WIDTH-1:0] v,
                       input logic rdy);
    clear = clr; enable = en; valid = v; out_ready = rdy;
  endtask

  task automatic add(input logic clr, input logic en, input logic [WIDTH-1:0] v,
                     input logic rdy, input logic ov, input logic [IDX_W-1:0] idx,
                     input logic [CNT_W-1:0] hc, input logic pa);
    vec_t r;
    r.clr = clr; r.en = en; r.v = v; r.rdy = rdy;
    r.ov = ov; r.idx = idx; r.hc = hc; r.pa = pa;
    vecs.push_back(r);
  endtask

  task automatic check_state(input string tag, input logic ov, input logic [CNT_W-1:0] hc,
                             input logic pa, input logic ac);
    check({tag, ".out_valid"}, IDX_W'(out_valid), IDX_W'(ov));
    check({tag, ".hit_count"}, IDX_W'(hit_count), IDX_W'(hc));
    check({tag, ".pending_any"}, IDX_W'(pending_any), IDX_W'(pa));
    check({tag, ".all_covered"}, IDX_W'(all_covered), IDX_W'(ac));
  endtask

  initial begin
    logic [WIDTH-1:0] b5, b7, b3, b0;
    b5 = '0; b5[5] = 1'b1;
    b7 = '0; b7[7] = 1'b1;
    b3 = '0; b3[3] = 1'b1;
    b0 = '0; b0[0] = 1'b1;

    // single hit
    add(0, 1, b5,     1, 0, 0,   1, 1);
    add(0, 0, '0,     1, 1, 105, 1, 1);
    add(0, 0, '0,     1, 0, 0,   1, 0);
    // burst ordering
    add(1, 0, '0,     1, 0, 0,   0, 0);
    add(0, 1, 40'h13, 1, 0, 0,   3, 1);
    add(0, 0, '0,     1, 1, 100, 3, 1);
    add(0, 0, '0,     1, 1, 101, 3, 1);
    add(0, 0, '0,     1, 1, 104, 3, 1);
    add(0, 0, '0,     1, 0, 0,   3, 0);
    // duplicate suppression
    add(1, 0, '0,     1, 0, 0,   0, 0);
    add(0, 1, b7,     1, 0, 0,   1, 1);
    add(0, 1, b7,     1, 1, 107, 1, 1);
    add(0, 1, b7,     1, 0, 0,   1, 0);
    add(0, 1, b7,     1, 0, 0,   1, 0);
    // backpressure: five cycles of out_ready low
    add(1, 0, '0,     1, 0, 0,   0, 0);
    add(0, 1, b0,     0, 0, 0,   1, 1);
    add(0, 0, '0,     0, 1, 100, 1, 1);
    add(0, 1, b3,     0, 1, 100, 2, 1);
    add(0, 0, '0,     0, 1, 100, 2, 1);
    add(0, 0, '0,     0, 1, 100, 2, 1);
    add(0, 0, '0,     1, 1, 103, 2, 1);
    add(0, 0, '0,     1, 0, 0,   2, 0);
    // enable low ignores hits
    add(0, 0, b5 | b7 | 40'h200, 1, 0, 0, 2, 0);

    drive(0, 0, '0, 0);
    reset = 1'b0;
    repeat (3) step();
    check("reset.out_index", out_index, 0);
    check_state("reset", 0, 0, 0, 0);
    reset = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].clr, vecs[i].en, vecs[i].v, vecs[i].rdy);
      step();
      check($sformatf("vec%0d.out_valid", i), IDX_W'(out_valid), IDX_W'(vecs[i].ov));
      check($sformatf("vec%0d.hit_count", i), IDX_W'(hit_count), IDX_W'(vecs[i].hc));
      check($sformatf("vec%0d.pending_any", i), IDX_W'(pending_any), IDX_W'(vecs[i].pa));
      if (vecs[i].ov) check($sformatf("vec%0d.out_index", i), out_index, vecs[i].idx);
    end

    // clear mid-drain beats same-cycle hit and handshake
    drive(1, 0, '0, 1); step();
    drive(0, 1, 40'h13, 1); step();
    drive(0, 0, '0, 1); step();
    check("clr_pre.out_index", out_index, 100);
    drive(1, 1, 40'h100000, 1); step();
    check_state("clr_mid", 0, 0, 0, 0);
    drive(0, 1, b0, 1); step();
    drive(0, 0, '0, 1); step();
    check("clr_rehit.out_valid", IDX_W'(out_valid), 1);
    check("clr_rehit.out_index", out_index, 100);
    check("clr_rehit.hit_count", IDX_W'(hit_count), 1);

    // reset mid-drain discards everything
    drive(1, 0, '0, 1); step();
    drive(0, 1, 40'h13, 1); step();
    drive(0, 0, '0, 0); step();
    reset = 1'b0;
    drive(0, 1, b5, 1); step();
    check_state("rst_mid", 0, 0, 0, 0);
    reset = 1'b1;
    drive(0, 0, '0, 1); step();
    check_state("rst_after", 0, 0, 0, 0);

    // full coverage: saturation and in-order drain under random backpressure
    drive(1, 0, '0, 0); step();
    drive(0, 1, '1, 0); step();
    check_state("full", 0, 15, 1, 1);
    for (int k = 0; k < WIDTH; k++) exp_q.push_back(IDX_W'(100 + k));
    drive(0, 0, '0, 0);
    for (int c = 0; c < 400 && exp_q.size() > 0; c++) begin
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid && out_ready) check("drain.out_index", out_index, exp_q.pop_front());
      step();
    end
    check("drain.remaining", IDX_W'(exp_q.size()), 0);
    out_ready = 1'b1;
    step();
    check_state("drained", 0, 15, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
